// File: rtl/tanh_share_arbiter.sv
// tanh_share_arbiter
// Round-robin share of one pipelined tanh unit among N_REQ requesters.
// A {vld, idx} tag travels beside each operand for LAT enabled cycles. When
// the tag leaves the last stage, the tanh output is routed back to the
// requester that issued the operand. Data is passed through unchanged; FL
// only documents the fixed-point format shared with the tanh unit.
module tanh_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int FL    = 24,
    parameter int N_REQ = 4,
    parameter int LAT   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic                   o_tanh_en,
    output logic                   o_tanh_rst,
    output logic [WIDTH-1:0]       o_tanh_a,
    input  logic [WIDTH-1:0]       i_tanh_y,
    output logic [N_REQ-1:0]       o_res_valid,
    output logic [WIDTH-1:0]       o_res_data,
    output logic                   o_busy
);
    localparam int IDX_W    = $clog2(N_REQ);
    localparam int INT_BITS = WIDTH - FL;

    // Reject parameter sets the datapath cannot represent
    if (INT_BITS < 1 || N_REQ < 2 || LAT < 1) begin : g_bad_params
        $error("tanh_share_arbiter: need FL < WIDTH, N_REQ >= 2, LAT >= 1");
    end

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [IDX_W-1:0]              r_rr_ptr;
    tag_t [LAT-1:0]                r_tag;

    logic [N_REQ-1:0][WIDTH-1:0]   w_req_data;
    logic                          w_found;
    logic [IDX_W-1:0]              w_winner;
    logic                          w_grant;
    tag_t                          w_tag_out;

    assign w_req_data = i_req_data;
    assign w_tag_out  = r_tag[LAT-1];

    // Rotating priority search starting at r_rr_ptr; first valid wins.
    // The data bus never enters this search, so ready is data-independent.
    always_comb begin
        logic [IDX_W:0] sum;
        w_found  = 1'b0;
        w_winner = '0;
        sum      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && i_req_valid[sum[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = sum[IDX_W-1:0];
            end
        end
    end

    // A grant is only issued when the whole path will advance this edge
    assign w_grant = w_found & i_en & i_rst;

    // One-hot ready and the operand mux toward the tanh unit
    always_comb begin
        o_req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            o_req_ready[i] = w_grant && (w_winner == IDX_W'(i));
        end
        o_tanh_a = w_grant ? w_req_data[w_winner] : '0;
    end

    // The tanh unit shares our advance and reset so the tag pipe stays aligned
    assign o_tanh_en  = i_en;
    assign o_tanh_rst = i_rst;

    // Round-robin pointer: the position after the last winner gets top priority
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_winner == IDX_W'(N_REQ-1)) ? '0 : w_winner + 1'b1;
        end
    end

    // Tag pipeline, frozen together with the tanh registers when en is low
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_tag <= '0;
        end else if (i_en) begin
            r_tag[0] <= '{vld: w_grant, idx: w_winner};
            for (int k = 1; k < LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Result steering from the registered tag at the end of the pipe
    always_comb begin
        o_res_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            o_res_valid[i] = w_tag_out.vld && (w_tag_out.idx == IDX_W'(i));
        end
        o_res_data = w_tag_out.vld ? i_tanh_y : '0;
    end

    // Busy while any stage still carries an operand
    always_comb begin
        o_busy = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            o_busy = o_busy | r_tag[k].vld;
        end
    end

endmodule
